// File: rtl/program_rom_port.sv
// Read port between a fetch/bus requester and a fixed-latency synchronous program ROM.
// Optional misaligned-address reporting is enabled with PROGRAM_ROM_PORT_ALIGN_CHECK_EN.
module program_rom_port #(
  parameter int ADDR_WIDTH  = 14,
  parameter int DATA_WIDTH  = 32,
  parameter int ROM_LATENCY = 1,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                                        clk,
  input  logic                                        reset_n,
  input  logic [ADDR_WIDTH-1:0]                       addr,
  input  logic                                        read_req,
  output logic                                        read_req_ready,
  output logic [DATA_WIDTH-1:0]                       read_data,
  output logic                                        read_data_valid,
  input  logic                                        read_data_ready,
`ifdef PROGRAM_ROM_PORT_ALIGN_CHECK_EN
  output logic                                        read_error,
`endif
  output logic [ADDR_WIDTH-$clog2(DATA_WIDTH/8)-1:0]  program_rom_addr,
  input  logic [DATA_WIDTH-1:0]                       program_rom_q
);

  localparam int OFFS  = $clog2(DATA_WIDTH / 8);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                  accept;
  logic                  ret;
  logic                  fifoEmpty;
  logic                  push;
  logic                  pop;
  logic                  handshake;
  logic                  misaligned;
  logic [DATA_WIDTH-1:0] retData;

  logic [ROM_LATENCY-1:0] flight_q, flight_d;
  logic [DATA_WIDTH-1:0]  mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]       wPtr_q, wPtr_d;
  logic [PTR_W-1:0]       rPtr_q, rPtr_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [CNT_W-1:0]       outstanding_q, outstanding_d;

  assign program_rom_addr = addr[ADDR_WIDTH-1:OFFS];

  generate
    if (OFFS > 0) begin : gLowBits
      assign misaligned = |addr[OFFS-1:0];
    end else begin : gNoLowBits
      assign misaligned = 1'b0;
    end
  endgenerate

  assign accept         = read_req && read_req_ready;
  assign read_req_ready = (outstanding_q < CNT_W'(FIFO_DEPTH));
  assign ret            = flight_q[ROM_LATENCY-1];
  assign fifoEmpty      = (count_q == '0);
  assign handshake      = read_data_valid && read_data_ready;
  assign pop            = !fifoEmpty && read_data_ready;
  // A returning word that is consumed straight through the bypass never enters the FIFO.
  assign push           = ret && !(fifoEmpty && read_data_ready);

  assign flight_d = ROM_LATENCY'({flight_q, accept});

`ifdef PROGRAM_ROM_PORT_ALIGN_CHECK_EN
  logic [ROM_LATENCY-1:0] errFlight_q, errFlight_d;
  logic                   errMem_q [FIFO_DEPTH];
  logic                   retErr;

  assign errFlight_d = ROM_LATENCY'({errFlight_q, accept && misaligned});
  assign retErr      = errFlight_q[ROM_LATENCY-1];
  assign retData     = retErr ? '0 : program_rom_q;
  assign read_error  = read_data_valid && (fifoEmpty ? retErr : errMem_q[rPtr_q]);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      errFlight_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        errMem_q[i] <= 1'b0;
      end
    end else begin
      errFlight_q <= errFlight_d;
      if (push) begin
        errMem_q[wPtr_q] <= retErr;
      end
    end
  end
`else
  logic unusedMisaligned;
  assign unusedMisaligned = misaligned;
  assign retData          = program_rom_q;
`endif

  // Read data idles at the FIFO head so the bus does not toggle when nothing is valid.
  always_comb begin
    read_data       = mem_q[rPtr_q];
    read_data_valid = 1'b0;
    if (!fifoEmpty) begin
      read_data_valid = 1'b1;
    end else if (ret) begin
      read_data       = retData;
      read_data_valid = 1'b1;
    end
  end

  always_comb begin
    wPtr_d        = wPtr_q;
    rPtr_d        = rPtr_q;
    count_d       = count_q;
    outstanding_d = outstanding_q;
    if (push) begin
      wPtr_d = wPtr_q + PTR_W'(1);
    end
    if (pop) begin
      rPtr_d = rPtr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    case ({accept, handshake})
      2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
      2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      flight_q      <= '0;
      wPtr_q        <= '0;
      rPtr_q        <= '0;
      count_q       <= '0;
      outstanding_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      flight_q      <= flight_d;
      wPtr_q        <= wPtr_d;
      rPtr_q        <= rPtr_d;
      count_q       <= count_d;
      outstanding_q <= outstanding_d;
      if (push) begin
        mem_q[wPtr_q] <= retData;
      end
    end
  end

endmodule

// File: doc/program_rom_port.md
Name: program_rom_port

Overview:
- Parametrised read port between a requester (instruction fetch or bus) and a synchronous program ROM with fixed read latency.
- Adds pipelined back-to-back reads, configurable ROM latency and width, and consumer backpressure.
- A credit-limited response FIFO guarantees no data is dropped.
- Sits between the fetch unit and the ROM macro instance.

Parameters:
- ADDR_WIDTH, 14, byte address width on the requester side.
- DATA_WIDTH, 32, word width; must be a power of two, at least 8.
- ROM_LATENCY, 1, cycles from program_rom_addr presented to program_rom_q valid; range 1..4.
- FIFO_DEPTH, 4, response buffer entries; must be at least ROM_LATENCY+1, power of two.

Ports:
- reset_n  input  1  asynchronous active-low reset
- clk  input  1  clock, all state on rising edge
- addr  input  ADDR_WIDTH  byte address of request
- read_req  input  1  request strobe
- read_req_ready  output  1  port can accept a request this cycle
- read_data  output  DATA_WIDTH  response word
- read_data_valid  output  1  read_data valid this cycle
- read_data_ready  input  1  consumer takes response this cycle
- program_rom_addr  output  ADDR_WIDTH-OFFS  word address to ROM; OFFS = clog2(DATA_WIDTH/8)
- program_rom_q  input  DATA_WIDTH  ROM data, valid ROM_LATENCY cycles after address

Behaviour:
- Reset: asynchronous, active-low, on reset_n.
- Reset values:
  - in-flight valid shift register all 0
  - FIFO empty; read/write pointers 0
  - outstanding counter 0
  - read_data_valid = 0, read_req_ready = 1
- program_rom_addr = addr[ADDR_WIDTH-1:OFFS], combinational. The ROM registers it internally.
- Accept: a request is accepted when read_req && read_req_ready. Address is not held after accept.
- Credits:
  - outstanding = in-flight count + FIFO occupancy; counter width clog2(FIFO_DEPTH+1).
  - read_req_ready = (outstanding < FIFO_DEPTH).
  - outstanding +1 on accept, -1 on response handshake (read_data_valid && read_data_ready); both in the same cycle means no change.
  - The FIFO can therefore never overflow.
- In-flight tracking: ROM_LATENCY-bit shift register. Bit 0 is loaded with the accept flag. The pipeline exit bit, ret, marks program_rom_q valid this cycle.
- Output selection:
  - FIFO non-empty: read_data = FIFO head; read_data_valid = 1.
  - FIFO empty and ret: bypass, read_data = program_rom_q; read_data_valid = 1.
  - Otherwise read_data_valid = 0. read_data is don't-care but held at FIFO head to avoid toggling.
- FIFO write: on ret unless (FIFO empty && read_data_ready), i.e. a bypass word that was consumed is not stored. Ordering is strictly in request order.
- FIFO read: pop head on handshake while non-empty. Push and pop in the same cycle is legal; occupancy is unchanged.
- Latency:
  - With empty FIFO and ready consumer, response is valid exactly ROM_LATENCY cycles after accept.
  - Default parameters match the legacy 1-cycle behaviour.
- Throughput: 1 request per cycle sustained while read_data_ready = 1.
- Stall: with read_data_ready = 0, read_data_valid and read_data hold stable until taken.
- Boundaries:
  - Pointers wrap modulo FIFO_DEPTH.
  - read_req_ready deasserts the cycle after outstanding reaches FIFO_DEPTH. It reasserts the cycle after the handshake that frees a credit; combinational same-cycle release is not provided.
  - Reset mid-operation discards in-flight reads and FIFO contents; no response is produced for them.

Optional Feature:
- Macro: PROGRAM_ROM_PORT_ALIGN_CHECK_EN
- Defined:
  - Adds output port read_error (1 bit, reset 0).
  - A request with addr[OFFS-1:0] != 0 is still accepted and consumes a credit, but does not use ROM data.
  - Its response returns in order with read_data = 0 and read_error = 1.
  - The flag travels in an extra bit of the shift register and FIFO.
  - read_error is valid only when read_data_valid = 1; 0 otherwise.
- Undefined: no read_error port; low address bits are ignored silently.

Test Plan:
- Single read, defaults: accept addr=0x0010 at cycle N, ROM returns 0xDEADBEEF → read_data_valid=1 with 0xDEADBEEF at N+1; program_rom_addr=0x004.
- Back-to-back, ROM_LATENCY=2: reads 0x0,0x4,0x8,0xC on consecutive cycles, ready=1 → four responses on consecutive cycles starting accept+2, in order; read_req_ready stays 1.
- Backpressure, defaults: read_data_ready=0, read_req held 1 → exactly 4 accepts, then read_req_ready=0. Raise ready → 4 words drain in order, one per cycle; ready reasserts after the first pop.
- Simultaneous push/pop: FIFO holding 2 entries, new return plus consumer pop in the same cycle → occupancy stays 2, order preserved, no lost word.
- Reset mid-operation: assert reset_n=0 with 3 outstanding → read_data_valid=0 immediately (async); after release, no stale responses and read_req_ready=1.
- With PROGRAM_ROM_PORT_ALIGN_CHECK_EN: reads 0x0002 then 0x0004 → first response read_error=1 and data 0; second response read_error=0 with ROM data.
